// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator.
package axis_frame_gen_pkg;

    // Two-state transmitter: waiting for a command, or streaming a frame.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Widest tkeep the helper can describe (512-bit data bus).
    localparam int MAX_KEEP = 64;

    // Byte-enable mask for a beat that starts with 'rem' bytes still to send.
    // A full beat (rem >= kw) gets kw ones; a short final beat gets the low rem bits.
    function automatic logic [MAX_KEEP-1:0] keep_mask(input logic [31:0] rem, input int kw);
        logic [MAX_KEEP-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KEEP; i++) begin
            if ((i < kw) && (32'(i) < rem)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// Command and AXI-Stream bundle for the frame generator.
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid && ready; the source keeps valid and its payload stable until that edge,
// and ready may depend combinationally on the other side.
interface axis_frame_gen_if
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [DEST_WIDTH-1:0] cmd_dest;
    logic                  cmd_bad;
    logic [7:0]            cmd_seed;

    // Stream channel
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [ID_WIDTH-1:0]   m_axis_tid;
    logic [DEST_WIDTH-1:0] m_axis_tdest;
    logic [USER_WIDTH-1:0] m_axis_tuser;

    // Generator side: accepts commands, drives the stream.
    modport master (
        input  cmd_valid, cmd_len, cmd_id, cmd_dest, cmd_bad, cmd_seed,
        output cmd_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tid, m_axis_tdest, m_axis_tuser,
        input  m_axis_tready
    );

    // Environment side: issues commands, sinks the stream.
    modport slave (
        output cmd_valid, cmd_len, cmd_id, cmd_dest, cmd_bad, cmd_seed,
        input  cmd_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tid, m_axis_tdest, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame transmitter: one command becomes one frame whose bytes are
// a ramp starting at the command seed. All stream outputs are registered.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int                    DATA_WIDTH           = 8,
    parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int                    ID_WIDTH             = 8,
    parameter int                    DEST_WIDTH           = 8,
    parameter int                    USER_WIDTH           = 1,
    parameter int                    LEN_WIDTH            = 16,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1)
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_frame_gen_if.master   bus,
    output logic               status_busy,
    output logic               status_frame_done,
    output logic [15:0]        frame_count
);

    localparam logic [LEN_WIDTH:0] KW_L = (LEN_WIDTH + 1)'(KEEP_WIDTH);
    localparam logic [7:0]         KW_B = 8'(KEEP_WIDTH);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [USER_WIDTH-1:0] r_tuser;
    logic [ID_WIDTH-1:0]   r_tid;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [LEN_WIDTH:0]    r_rem;   // bytes left, counting the beat on the bus
    logic [7:0]            r_byte;  // ramp value of lane 0 of the beat on the bus
    logic                  r_bad;
    logic                  r_done;
    logic [15:0]           r_count;

    logic                  w_handshake;
    logic                  w_last_hs;
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_load;
    logic [LEN_WIDTH:0]    w_cmd_len;
    logic [LEN_WIDTH:0]    w_src_rem;
    logic [7:0]            w_src_byte;
    logic                  w_src_bad;
    logic                  w_last;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic [DATA_WIDTH-1:0] w_data;
    logic [USER_WIDTH-1:0] w_user;

    // A new command can be taken while idle, or in the very cycle the final beat
    // leaves, which is what lets frames run back to back with no idle beat.
    assign w_handshake = r_tvalid && bus.m_axis_tready;
    assign w_last_hs   = w_handshake && r_tlast;
    assign w_cmd_ready = (r_state == IDLE) || w_last_hs;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_load      = w_accept || (w_handshake && !r_tlast);
    assign w_cmd_len   = (bus.cmd_len == '0) ? (LEN_WIDTH + 1)'(1) : {1'b0, bus.cmd_len};

    // Build the next beat, either the first beat of a fresh command or the
    // successor of the beat currently on the bus.
    always_comb begin
        w_src_rem  = r_rem - KW_L;
        w_src_byte = r_byte + KW_B;
        w_src_bad  = r_bad;
        if (w_accept) begin
            w_src_rem  = w_cmd_len;
            w_src_byte = bus.cmd_seed;
            w_src_bad  = bus.cmd_bad;
        end
        w_last = (w_src_rem <= KW_L);
        w_keep = KEEP_WIDTH'(keep_mask(32'(w_src_rem), KEEP_WIDTH));
        w_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_data[i*8 +: 8] = w_keep[i] ? (w_src_byte + 8'(i)) : 8'h00;
        end
        w_user = (w_last && w_src_bad) ? USER_BAD_FRAME_VALUE : '0;
    end

    // FSM, output beat register, beat counter and frame statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
            r_tid    <= '0;
            r_tdest  <= '0;
            r_rem    <= '0;
            r_byte   <= '0;
            r_bad    <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= w_last_hs;
            if (w_last_hs) begin
                r_count <= r_count + 16'd1;
            end
            if (w_load) begin
                r_tdata <= w_data;
                r_tkeep <= w_keep;
                r_tlast <= w_last;
                r_tuser <= w_user;
                r_rem   <= w_src_rem;
                r_byte  <= w_src_byte;
                r_bad   <= w_src_bad;
            end
            if (w_accept) begin
                r_state  <= SEND;
                r_tvalid <= 1'b1;
                r_tid    <= bus.cmd_id;
                r_tdest  <= bus.cmd_dest;
            end else if (w_last_hs) begin
                r_state  <= IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tuser  <= '0;
            end
        end
    end

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tkeep  = r_tkeep;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.m_axis_tlast  = r_tlast;
    assign bus.m_axis_tuser  = r_tuser;
    assign bus.m_axis_tid    = r_tid;
    assign bus.m_axis_tdest  = r_tdest;

    assign status_busy       = (r_state == SEND);
    assign status_frame_done = r_done;
    assign frame_count       = r_count;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: an 8-bit and a 32-bit instance share clock/reset.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy8, done8, busy32, done32;
    logic [15:0] count8, count32;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];

    axis_frame_gen_if #(.DATA_WIDTH(8))  bus8 ();
    axis_frame_gen_if #(.DATA_WIDTH(32)) bus32 ();

    axis_frame_gen #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8),
        .status_busy(busy8), .status_frame_done(done8), .frame_count(count8)
    );

    axis_frame_gen #(.DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32),
        .status_busy(busy32), .status_frame_done(done32), .frame_count(count32)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver: present a command on the 8-bit instance until accepted.
    task automatic issue_cmd8(input logic [15:0] len, input logic [7:0] id, input logic [7:0] dest,
                              input logic bad, input logic [7:0] seed);
        bit got;
        got = 0;
        @(posedge clk); #1;
        bus8.cmd_valid = 1'b1; bus8.cmd_len = len; bus8.cmd_id = id;
        bus8.cmd_dest = dest; bus8.cmd_bad = bad; bus8.cmd_seed = seed;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus8.cmd_ready) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL cmd8_accept: cmd_ready stayed 0, required 1"); end
        @(posedge clk); #1;
        bus8.cmd_valid = 1'b0;
    endtask

    task automatic issue_cmd32(input logic [15:0] len, input logic [7:0] seed);
        bit got;
        got = 0;
        @(posedge clk); #1;
        bus32.cmd_valid = 1'b1; bus32.cmd_len = len; bus32.cmd_id = 8'h32;
        bus32.cmd_dest = 8'h05; bus32.cmd_bad = 1'b0; bus32.cmd_seed = seed;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus32.cmd_ready) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL cmd32_accept: cmd_ready stayed 0, required 1"); end
        @(posedge clk); #1;
        bus32.cmd_valid = 1'b0;
    endtask

    // Monitors: advance to the next negedge where a beat handshakes.
    task automatic wait_beat8(output bit ok);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus8.m_axis_tvalid && bus8.m_axis_tready) ok = 1;
        end
    endtask

    task automatic wait_beat32(output bit ok);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus32.m_axis_tvalid && bus32.m_axis_tready) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.cmd_valid = 0; bus8.cmd_len = 0; bus8.cmd_id = 0; bus8.cmd_dest = 0;
        bus8.cmd_bad = 0; bus8.cmd_seed = 0; bus8.m_axis_tready = 0;
        bus32.cmd_valid = 0; bus32.cmd_len = 0; bus32.cmd_id = 0; bus32.cmd_dest = 0;
        bus32.cmd_bad = 0; bus32.cmd_seed = 0; bus32.m_axis_tready = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus8.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b need 0", bus8.m_axis_tvalid); end
        checks++; if (bus8.m_axis_tlast !== 1'b0 || bus8.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tlast_tuser: got %b/%b need 0/0", bus8.m_axis_tlast, bus8.m_axis_tuser); end
        checks++; if (bus8.m_axis_tdata !== 8'h00 || bus8.m_axis_tkeep !== 1'b0) begin errors++; $display("FAIL rst_data: got %h/%b need 00/0", bus8.m_axis_tdata, bus8.m_axis_tkeep); end
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rst_status: got busy=%b done=%b need 0/0", busy8, done8); end
        checks++; if (count8 !== 16'h0) begin errors++; $display("FAIL rst_count: got %h need 0000", count8); end
        checks++; if (bus8.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b need 1", bus8.cmd_ready); end
        checks++; if (bus32.m_axis_tvalid !== 1'b0 || bus32.m_axis_tdata !== 32'h0 || bus32.m_axis_tid !== 8'h0) begin errors++; $display("FAIL rst_dw32: got tvalid=%b tdata=%h tid=%h need 0/0/0", bus32.m_axis_tvalid, bus32.m_axis_tdata, bus32.m_axis_tid); end
        rst_n = 1'b1;
        bus8.m_axis_tready = 1'b1;
        bus32.m_axis_tready = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] e;
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h10 + 8'(k));
        issue_cmd8(16'd3, 8'hA5, 8'h3C, 1'b0, 8'h10);
        for (int k = 0; k < 3; k++) begin
            wait_beat8(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || bus8.m_axis_tdata !== e || bus8.m_axis_tlast !== (k == 2)) begin
                errors++; $display("FAIL basic_beat%0d: got ok=%0d data=%h last=%b need data=%h last=%b", k, ok, bus8.m_axis_tdata, bus8.m_axis_tlast, e, (k == 2));
            end
            checks++;
            if (bus8.m_axis_tid !== 8'hA5 || bus8.m_axis_tdest !== 8'h3C || bus8.m_axis_tuser !== 1'b0 || busy8 !== 1'b1) begin
                errors++; $display("FAIL basic_side%0d: got id=%h dest=%h user=%b busy=%b need A5/3C/0/1", k, bus8.m_axis_tid, bus8.m_axis_tdest, bus8.m_axis_tuser, busy8);
            end
        end
        @(negedge clk);
        checks++; if (done8 !== 1'b1 || count8 !== 16'd1) begin errors++; $display("FAIL basic_done: got done=%b count=%0d need 1/1", done8, count8); end
        @(negedge clk);
        checks++; if (done8 !== 1'b0 || busy8 !== 1'b0 || bus8.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle: got done=%b busy=%b tvalid=%b need 0/0/0", done8, busy8, bus8.m_axis_tvalid); end
    endtask

    task automatic test_dw32();
        bit ok;
        issue_cmd32(16'd6, 8'hF0);
        wait_beat32(ok);
        checks++;
        if (!ok || bus32.m_axis_tdata !== 32'hF3F2F1F0 || bus32.m_axis_tkeep !== 4'hF || bus32.m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL dw32_beat0: got data=%h keep=%h last=%b need F3F2F1F0/F/0", bus32.m_axis_tdata, bus32.m_axis_tkeep, bus32.m_axis_tlast);
        end
        wait_beat32(ok);
        checks++;
        if (!ok || bus32.m_axis_tdata !== 32'h0000F5F4 || bus32.m_axis_tkeep !== 4'h3 || bus32.m_axis_tlast !== 1'b1) begin
            errors++; $display("FAIL dw32_beat1: got data=%h keep=%h last=%b need 0000F5F4/3/1", bus32.m_axis_tdata, bus32.m_axis_tkeep, bus32.m_axis_tlast);
        end
        @(negedge clk);
        checks++; if (done32 !== 1'b1 || count32 !== 16'd1) begin errors++; $display("FAIL dw32_done: got done=%b count=%0d need 1/1", done32, count32); end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int         hs;
        bit         stalled, got_last;
        logic [7:0] held_d, e;
        logic       held_l;
        pat = 4'b1001; hs = 0; stalled = 0; got_last = 0; held_d = 0; held_l = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h80 + 8'(k));
        issue_cmd8(16'd4, 8'h11, 8'h22, 1'b0, 8'h80);
        for (int c = 0; c < 40 && !got_last; c++) begin
            bus8.m_axis_tready = pat[c % 4];
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (bus8.m_axis_tvalid !== 1'b1 || bus8.m_axis_tdata !== held_d || bus8.m_axis_tlast !== held_l) begin
                    errors++; $display("FAIL stall_hold: got v=%b d=%h l=%b need 1/%h/%b", bus8.m_axis_tvalid, bus8.m_axis_tdata, bus8.m_axis_tlast, held_d, held_l);
                end
            end
            if (bus8.m_axis_tvalid && bus8.m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra: got beat %h, need none", bus8.m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus8.m_axis_tdata !== e || bus8.m_axis_tlast !== (exp_q.size() == 0)) begin
                        errors++; $display("FAIL stall_beat%0d: got %h last=%b need %h last=%b", hs, bus8.m_axis_tdata, bus8.m_axis_tlast, e, (exp_q.size() == 0));
                    end
                end
                hs++;
                got_last = bus8.m_axis_tlast;
            end
            stalled = bus8.m_axis_tvalid && !bus8.m_axis_tready;
            held_d = bus8.m_axis_tdata;
            held_l = bus8.m_axis_tlast;
            @(posedge clk); #1;
        end
        checks++; if (hs != 4 || exp_q.size() != 0) begin errors++; $display("FAIL stall_count: got %0d handshakes need 4", hs); end
        exp_q.delete();
        bus8.m_axis_tready = 1'b1;
        @(negedge clk);
        checks++; if (done8 !== 1'b1 || count8 !== 16'd2) begin errors++; $display("FAIL stall_done: got done=%b count=%0d need 1/2", done8, count8); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        issue_cmd8(16'd2, 8'h01, 8'h10, 1'b0, 8'h20);
        bus8.cmd_valid = 1'b1; bus8.cmd_len = 16'd2; bus8.cmd_id = 8'h02;
        bus8.cmd_dest = 8'h10; bus8.cmd_bad = 1'b0; bus8.cmd_seed = 8'h40;
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h20 || bus8.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL b2b_f1b0: got %h last=%b need 20/0", bus8.m_axis_tdata, bus8.m_axis_tlast); end
        checks++; if (bus8.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_mid: got %b need 0", bus8.cmd_ready); end
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h21 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL b2b_f1b1: got %h last=%b need 21/1", bus8.m_axis_tdata, bus8.m_axis_tlast); end
        checks++; if (bus8.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last: got %b need 1", bus8.cmd_ready); end
        @(posedge clk); #1;
        bus8.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.m_axis_tvalid !== 1'b1 || bus8.m_axis_tdata !== 8'h40 || bus8.m_axis_tid !== 8'h02 || bus8.m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL b2b_f2b0: got v=%b d=%h id=%h l=%b need 1/40/02/0", bus8.m_axis_tvalid, bus8.m_axis_tdata, bus8.m_axis_tid, bus8.m_axis_tlast);
        end
        checks++; if (done8 !== 1'b1 || count8 !== 16'd3) begin errors++; $display("FAIL b2b_done1: got done=%b count=%0d need 1/3", done8, count8); end
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h41 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL b2b_f2b1: got %h last=%b need 41/1", bus8.m_axis_tdata, bus8.m_axis_tlast); end
        @(negedge clk);
        checks++; if (done8 !== 1'b1 || count8 !== 16'd4) begin errors++; $display("FAIL b2b_done2: got done=%b count=%0d need 1/4", done8, count8); end
    endtask

    task automatic test_bad();
        bit ok;
        issue_cmd8(16'd2, 8'h07, 8'h08, 1'b1, 8'h05);
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h05 || bus8.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL bad_b0: got %h user=%b need 05/0", bus8.m_axis_tdata, bus8.m_axis_tuser); end
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h06 || bus8.m_axis_tuser !== 1'b1 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL bad_b1: got %h user=%b last=%b need 06/1/1", bus8.m_axis_tdata, bus8.m_axis_tuser, bus8.m_axis_tlast); end
        issue_cmd8(16'd2, 8'h07, 8'h08, 1'b0, 8'hFF);
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'hFF || bus8.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL good_b0: got %h user=%b need FF/0", bus8.m_axis_tdata, bus8.m_axis_tuser); end
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h00 || bus8.m_axis_tuser !== 1'b0 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL good_b1: got %h user=%b last=%b need 00/0/1", bus8.m_axis_tdata, bus8.m_axis_tuser, bus8.m_axis_tlast); end
        @(negedge clk);
        checks++; if (count8 !== 16'd6) begin errors++; $display("FAIL bad_count: got %0d need 6", count8); end
    endtask

    task automatic test_len0();
        bit ok;
        issue_cmd8(16'd0, 8'h09, 8'h0A, 1'b0, 8'h33);
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h33 || bus8.m_axis_tkeep !== 1'b1 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL len0_dw8: got %h keep=%b last=%b need 33/1/1", bus8.m_axis_tdata, bus8.m_axis_tkeep, bus8.m_axis_tlast); end
        @(negedge clk);
        checks++; if (count8 !== 16'd7 || bus8.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL len0_dw8_end: got count=%0d tvalid=%b need 7/0", count8, bus8.m_axis_tvalid); end
        issue_cmd32(16'd0, 8'h77);
        wait_beat32(ok);
        checks++; if (!ok || bus32.m_axis_tdata !== 32'h00000077 || bus32.m_axis_tkeep !== 4'h1 || bus32.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL len0_dw32: got %h keep=%h last=%b need 00000077/1/1", bus32.m_axis_tdata, bus32.m_axis_tkeep, bus32.m_axis_tlast); end
        @(negedge clk);
        checks++; if (count32 !== 16'd2) begin errors++; $display("FAIL len0_dw32_count: got %0d need 2", count32); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        issue_cmd8(16'd5, 8'h0C, 8'h0D, 1'b0, 8'h50);
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h50) begin errors++; $display("FAIL mid_b0: got %h need 50", bus8.m_axis_tdata); end
        @(negedge clk);
        checks++; if (bus8.m_axis_tdata !== 8'h51 || bus8.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_b1: got %h v=%b need 51/1", bus8.m_axis_tdata, bus8.m_axis_tvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus8.m_axis_tvalid !== 1'b0 || bus8.m_axis_tlast !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL mid_trunc: got v=%b l=%b busy=%b need 0/0/0", bus8.m_axis_tvalid, bus8.m_axis_tlast, busy8); end
        checks++; if (count8 !== 16'd0 || done8 !== 1'b0) begin errors++; $display("FAIL mid_count: got count=%0d done=%b need 0/0", count8, done8); end
        @(negedge clk);
        rst_n = 1'b1;
        issue_cmd8(16'd2, 8'h0E, 8'h0F, 1'b0, 8'h60);
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h60 || bus8.m_axis_tid !== 8'h0E) begin errors++; $display("FAIL mid_next_b0: got %h id=%h need 60/0E", bus8.m_axis_tdata, bus8.m_axis_tid); end
        wait_beat8(ok);
        checks++; if (!ok || bus8.m_axis_tdata !== 8'h61 || bus8.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL mid_next_b1: got %h last=%b need 61/1", bus8.m_axis_tdata, bus8.m_axis_tlast); end
        @(negedge clk);
        checks++; if (count8 !== 16'd1 || done8 !== 1'b1) begin errors++; $display("FAIL mid_next_done: got count=%0d done=%b need 1/1", count8, done8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dw32();
        test_stall();
        test_back_to_back();
        test_bad();
        test_len0();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
